// File: rtl/n2p_pkg.sv
// Shared types and constants for the node-to-port VC ingress buffer.
package n2p_pkg;

    localparam int unsigned N2P_DATA_WIDTH = 9;
    localparam int unsigned N2P_NUM_VC     = 2;
    localparam int unsigned N2P_VCW        = (N2P_NUM_VC > 1) ? $clog2(N2P_NUM_VC) : 1;
    localparam int unsigned N2P_MAX_DW     = 64;

    typedef logic [N2P_VCW-1:0]        vc_idx_t;
    typedef logic [N2P_DATA_WIDTH-1:0] flit_t;

    // Idle word: MSB set, all other bits zero; callers truncate to their flit width.
    function automatic logic [N2P_MAX_DW-1:0] idle_flit(input int unsigned dw);
        return N2P_MAX_DW'(1) << (dw - 1);
    endfunction

endpackage

// File: rtl/n2p_vc_ctrl.sv
// Per-VC pointer/occupancy tracker: accepts requests, produces empty/full/almost-full.
module n2p_vc_ctrl
    import n2p_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH   = 2,
    parameter int unsigned AFULL_THRESH = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_req_i,
    input  logic                  rd_req_i,
    output logic                  wr_acc_c,
    output logic                  rd_acc_c,
    output logic                  empty_c,
    output logic                  full_c,
    output logic                  afull_c,
    output logic [ADDR_WIDTH-1:0] wptr_o,
    output logic [ADDR_WIDTH-1:0] rptr_o,
    output logic [ADDR_WIDTH:0]   count_o
);

    localparam int unsigned DEPTH = 1 << ADDR_WIDTH;
    localparam int unsigned CW    = ADDR_WIDTH + 1;

    logic [ADDR_WIDTH-1:0] wptr_q, wptr_d;
    logic [ADDR_WIDTH-1:0] rptr_q, rptr_d;
    logic [CW-1:0]         count_q, count_d;

    // Full is judged on the pre-edge count, so a same-cycle read never frees room for a write.
    assign empty_c  = (count_q == '0);
    assign full_c   = (count_q == CW'(DEPTH));
    assign afull_c  = (count_q >= CW'(AFULL_THRESH));
    assign wr_acc_c = wr_req_i && !full_c;
    assign rd_acc_c = rd_req_i && !empty_c;

    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        if (wr_acc_c) wptr_d = wptr_q + ADDR_WIDTH'(1);
        if (rd_acc_c) rptr_d = rptr_q + ADDR_WIDTH'(1);
        if (wr_acc_c && !rd_acc_c) count_d = count_q + CW'(1);
        else if (rd_acc_c && !wr_acc_c) count_d = count_q - CW'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

    assign wptr_o  = wptr_q;
    assign rptr_o  = rptr_q;
    assign count_o = count_q;

endmodule

// File: rtl/n2p_vc_fifo.sv
// Node-to-port ingress buffer: NUM_VC independent FIFOs, one write and one read per cycle.
// Optional sticky overflow/underflow flags with err_clr when N2P_VC_FIFO_ERR_EN is defined.
module n2p_vc_fifo
    import n2p_pkg::*;
#(
    parameter int unsigned DATA_WIDTH   = N2P_DATA_WIDTH,
    parameter int unsigned ADDR_WIDTH   = 2,
    parameter int unsigned NUM_VC       = N2P_NUM_VC,
    parameter int unsigned AFULL_THRESH = (1 << ADDR_WIDTH) - 1,
    localparam int unsigned VCW         = (NUM_VC > 1) ? $clog2(NUM_VC) : 1,
    localparam int unsigned CW          = ADDR_WIDTH + 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   wr_en,
    input  logic [VCW-1:0]         wr_vc,
    input  logic [DATA_WIDTH-1:0]  data_in,
    input  logic                   rd_en,
    input  logic [VCW-1:0]         rd_vc,
    output logic [DATA_WIDTH-1:0]  data_out,
    output logic                   rd_valid,
    output logic [NUM_VC-1:0]      empty,
    output logic [NUM_VC-1:0]      full,
    output logic [NUM_VC-1:0]      afull,
`ifdef N2P_VC_FIFO_ERR_EN
    input  logic                   err_clr,
    output logic [NUM_VC-1:0]      ovf_err,
    output logic [NUM_VC-1:0]      udf_err,
`endif
    output logic [NUM_VC*CW-1:0]   count
);

    localparam int unsigned DEPTH = 1 << ADDR_WIDTH;
    localparam logic [DATA_WIDTH-1:0] IDLE = DATA_WIDTH'(idle_flit(DATA_WIDTH));

    logic [NUM_VC-1:0]     wr_req, rd_req, wr_acc, rd_acc;
    logic [ADDR_WIDTH-1:0] wptr [NUM_VC];
    logic [ADDR_WIDTH-1:0] rptr [NUM_VC];
    logic [DATA_WIDTH-1:0] head [NUM_VC];
    logic [DATA_WIDTH-1:0] head_c;
    logic [DATA_WIDTH-1:0] data_out_q;
    logic                  rd_valid_q;

    for (genvar v = 0; v < NUM_VC; v++) begin : g_vc
        logic [DATA_WIDTH-1:0] mem_q [DEPTH];

        // Out-of-range VC indices never match any v, so they are ignored here.
        assign wr_req[v] = wr_en && (wr_vc == VCW'(v));
        assign rd_req[v] = rd_en && (rd_vc == VCW'(v));

        n2p_vc_ctrl #(
            .ADDR_WIDTH   (ADDR_WIDTH),
            .AFULL_THRESH (AFULL_THRESH)
        ) u_ctrl (
            .clk      (clk),
            .rst      (rst),
            .wr_req_i (wr_req[v]),
            .rd_req_i (rd_req[v]),
            .wr_acc_c (wr_acc[v]),
            .rd_acc_c (rd_acc[v]),
            .empty_c  (empty[v]),
            .full_c   (full[v]),
            .afull_c  (afull[v]),
            .wptr_o   (wptr[v]),
            .rptr_o   (rptr[v]),
            .count_o  (count[v*CW +: CW])
        );

        always_ff @(posedge clk) begin
            if (wr_acc[v]) mem_q[wptr[v]] <= data_in;
        end

        assign head[v] = mem_q[rptr[v]];
    end

    // At most one VC accepts a read per cycle.
    always_comb begin
        head_c = IDLE;
        for (int v = 0; v < NUM_VC; v++) begin
            if (rd_acc[v]) head_c = head[v];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_out_q <= IDLE;
            rd_valid_q <= 1'b0;
        end else begin
            data_out_q <= head_c;
            rd_valid_q <= |rd_acc;
        end
    end

    assign data_out = data_out_q;
    assign rd_valid = rd_valid_q;

`ifdef N2P_VC_FIFO_ERR_EN
    logic [NUM_VC-1:0] ovf_q, udf_q;

    // Sticky flags; a new error wins over a same-cycle clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf_q <= '0;
            udf_q <= '0;
        end else begin
            ovf_q <= (ovf_q & ~{NUM_VC{err_clr}}) | (wr_req & full);
            udf_q <= (udf_q & ~{NUM_VC{err_clr}}) | (rd_req & empty);
        end
    end

    assign ovf_err = ovf_q;
    assign udf_err = udf_q;
`endif

endmodule

// File: tb/tb_n2p_vc_fifo.sv
// Directed self-checking bench for n2p_vc_fifo (DATA_WIDTH=9, ADDR_WIDTH=2, NUM_VC=2).
// Error-flag checks are active when N2P_VC_FIFO_ERR_EN is defined.
module tb_n2p_vc_fifo;

    logic       clk;
    logic       rst;
    logic       wr_en;
    logic [0:0] wr_vc;
    logic [8:0] data_in;
    logic       rd_en;
    logic [0:0] rd_vc;
    logic [8:0] data_out;
    logic       rd_valid;
    logic [1:0] empty, full, afull;
    logic [5:0] count;
`ifdef N2P_VC_FIFO_ERR_EN
    logic       err_clr;
    logic [1:0] ovf_err, udf_err;
`endif

    int errs;
    int checks;

    n2p_vc_fifo dut (
        .clk      (clk),
        .rst      (rst),
        .wr_en    (wr_en),
        .wr_vc    (wr_vc),
        .data_in  (data_in),
        .rd_en    (rd_en),
        .rd_vc    (rd_vc),
        .data_out (data_out),
        .rd_valid (rd_valid),
        .empty    (empty),
        .full     (full),
        .afull    (afull),
`ifdef N2P_VC_FIFO_ERR_EN
        .err_clr  (err_clr),
        .ovf_err  (ovf_err),
        .udf_err  (udf_err),
`endif
        .count    (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // One cycle of stimulus; outputs are sampled 1ns after the edge.
    task automatic step(input logic we, input logic wvc, input logic [8:0] wd,
                        input logic re, input logic rvc);
        wr_en   = we;
        wr_vc   = wvc;
        data_in = wd;
        rd_en   = re;
        rd_vc   = rvc;
        @(posedge clk);
        #1;
        wr_en = 1'b0;
        rd_en = 1'b0;
    endtask

    logic [8:0] q[$];
    logic [8:0] exp_d;

    initial begin
        errs = 0;
        checks = 0;
        rst = 1'b1;
        wr_en = 1'b0; wr_vc = '0; data_in = '0;
        rd_en = 1'b0; rd_vc = '0;
`ifdef N2P_VC_FIFO_ERR_EN
        err_clr = 1'b0;
`endif
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst_data", 32'(data_out), 32'h100);
        check("rst_valid", 32'(rd_valid), 0);
        check("rst_empty", 32'(empty), 32'h3);
        check("rst_full", 32'(full), 0);
        check("rst_afull", 32'(afull), 0);
        check("rst_count", 32'(count), 0);

        // Fill VC0, overflow attempt, then drain in order.
        for (int i = 1; i <= 4; i++) begin
            step(1'b1, 1'b0, 9'(i), 1'b0, 1'b0);
            check("fill_count0", 32'(count[2:0]), 32'(i));
        end
        check("fill_full", 32'(full), 32'h1);
        check("fill_afull", 32'(afull), 32'h1);
        step(1'b1, 1'b0, 9'h05, 1'b0, 1'b0);
        check("ovf_count0", 32'(count[2:0]), 4);
`ifdef N2P_VC_FIFO_ERR_EN
        check("ovf_err0", 32'(ovf_err), 32'h1);
`endif
        for (int i = 1; i <= 4; i++) begin
            step(1'b0, 1'b0, 9'h0, 1'b1, 1'b0);
            check("drain_data", 32'(data_out), 32'(i));
            check("drain_valid", 32'(rd_valid), 1);
        end
        check("drain_empty", 32'(empty), 32'h3);

        // Read from empty VC1.
        step(1'b0, 1'b0, 9'h0, 1'b1, 1'b1);
        check("udf_data", 32'(data_out), 32'h100);
        check("udf_valid", 32'(rd_valid), 0);
        check("udf_count1", 32'(count[5:3]), 0);
`ifdef N2P_VC_FIFO_ERR_EN
        check("udf_err1", 32'(udf_err), 32'h2);
`endif

        // Same-VC simultaneous read+write at count 2, then wrap over 10 flits.
        step(1'b1, 1'b0, 9'h11, 1'b0, 1'b0);
        step(1'b1, 1'b0, 9'h12, 1'b0, 1'b0);
        q.push_back(9'h11);
        q.push_back(9'h12);
        step(1'b1, 1'b0, 9'h0A, 1'b1, 1'b0);
        q.push_back(9'h0A);
        exp_d = q.pop_front();
        check("rw_data", 32'(data_out), 32'(exp_d));
        check("rw_count0", 32'(count[2:0]), 2);
        for (int i = 0; i < 10; i++) begin
            step(1'b1, 1'b0, 9'(8'h20 + 8'(i)), 1'b1, 1'b0);
            q.push_back(9'(8'h20 + 8'(i)));
            exp_d = q.pop_front();
            check("wrap_data", 32'(data_out), 32'(exp_d));
            check("wrap_count0", 32'(count[2:0]), 2);
        end
        while (q.size() > 0) begin
            step(1'b0, 1'b0, 9'h0, 1'b1, 1'b0);
            exp_d = q.pop_front();
            check("wrap_tail", 32'(data_out), 32'(exp_d));
        end
        check("wrap_empty", 32'(empty), 32'h3);

        // Write VC1 while reading VC0: afull[0] drops, VC1 gains a flit.
        step(1'b1, 1'b0, 9'h31, 1'b0, 1'b0);
        step(1'b1, 1'b0, 9'h32, 1'b0, 1'b0);
        step(1'b1, 1'b0, 9'h33, 1'b0, 1'b0);
        check("il_afull_pre", 32'(afull), 32'h1);
        step(1'b1, 1'b1, 9'h55, 1'b1, 1'b0);
        check("il_data", 32'(data_out), 32'h31);
        check("il_count0", 32'(count[2:0]), 2);
        check("il_count1", 32'(count[5:3]), 1);
        check("il_afull", 32'(afull), 0);
        check("il_empty", 32'(empty), 0);

        // Full VC1: write dropped even with a same-VC read.
        step(1'b1, 1'b1, 9'h56, 1'b0, 1'b0);
        step(1'b1, 1'b1, 9'h57, 1'b0, 1'b0);
        step(1'b1, 1'b1, 9'h58, 1'b0, 1'b0);
        check("f1_full", 32'(full), 32'h2);
        step(1'b1, 1'b1, 9'h59, 1'b1, 1'b1);
        check("f1_data", 32'(data_out), 32'h55);
        check("f1_count1", 32'(count[5:3]), 3);
        check("f1_full_post", 32'(full), 0);
`ifdef N2P_VC_FIFO_ERR_EN
        check("f1_ovf", 32'(ovf_err), 32'h3);
        check("f1_udf", 32'(udf_err), 32'h2);
        err_clr = 1'b1;
        step(1'b0, 1'b0, 9'h0, 1'b0, 1'b0);
        err_clr = 1'b0;
        check("clr_ovf", 32'(ovf_err), 0);
        check("clr_udf", 32'(udf_err), 0);
`endif
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b0, 9'h0, 1'b1, 1'b1);
            check("f1_drain", 32'(data_out), 32'(9'h56 + 9'(i)));
        end
        check("f1_empty1", 32'(empty[1]), 1);

        // Async reset mid-traffic, with no clock edge before sampling.
        step(1'b0, 1'b0, 9'h0, 1'b1, 1'b0);
        check("pre_rst_data", 32'(data_out), 32'h32);
        check("pre_rst_count0", 32'(count[2:0]), 1);
        #1;
        rst = 1'b1;
        #1;
        check("arst_data", 32'(data_out), 32'h100);
        check("arst_valid", 32'(rd_valid), 0);
        check("arst_empty", 32'(empty), 32'h3);
        check("arst_count", 32'(count), 0);
        @(negedge clk);
        rst = 1'b0;
        step(1'b0, 1'b0, 9'h0, 1'b1, 1'b0);
        check("flush_data", 32'(data_out), 32'h100);
        check("flush_valid", 32'(rd_valid), 0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
